// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised multi-port register file.
// The byte-merge helper is used by both the write path and the read bypass.
package regfile_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_SWEEP,
        CLR_DONE
    } clr_state_t;

    localparam int BYTE_W = 8;

    function automatic int nlanes(input int data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic logic [BYTE_W-1:0] byte_merge(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              lane_en
    );
        return lane_en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read lane: block enable, hardwired-zero entry and
// optional write-to-read bypass of the byte-merged write data.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              i_ena,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_stored,
    input  logic              i_wr_qual,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_merged,
    output logic [DATA_W-1:0] o_data
);

    logic w_zero_hit;
    logic w_bypass_hit;

    assign w_zero_hit   = (ZERO_REG != 0) && (i_addr == '0);
    assign w_bypass_hit = (BYPASS != 0) && i_wr_qual && (i_addr == i_wr_addr);

    always_comb begin
        // NOTE: default assignment first so every path drives o_data and no latch is inferred.
        o_data = i_stored;
        if (w_bypass_hit) begin
            o_data = i_merged;
        end
        if (!i_ena || w_zero_hit) begin
            o_data = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NRD async read ports, one byte-enabled write
// port, optional bypass / zero entry, and a soft-clear sweep engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  reg_clk,
    input  logic                  rst,
    input  logic                  reg_ena,
    input  logic                  reg_w,
    input  logic [ADDR_W-1:0]     RdC,
    input  logic [DATA_W-1:0]     Rd_data_in,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NL    = nlanes(DATA_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_clr_busy;
    logic              r_clr_done;
    logic              r_wr_drop;

    logic              w_wr_req;
    logic              w_wr_qual;
    logic [DATA_W-1:0] w_wr_old;
    logic [DATA_W-1:0] w_merged;

    assign w_wr_req  = reg_ena && reg_w;
    assign w_wr_qual = w_wr_req && (r_state == CLR_IDLE)
                       && !((ZERO_REG != 0) && (RdC == '0));
    assign w_wr_old  = r_mem[RdC];

    for (genvar i = 0; i < NL; i++) begin : g_lane
        assign w_merged[i*BYTE_W +: BYTE_W] = byte_merge(w_wr_old[i*BYTE_W +: BYTE_W],
                                                         Rd_data_in[i*BYTE_W +: BYTE_W],
                                                         wr_be[i]);
    end

    // NOTE: storage is flops, not a RAM macro, because reset must zero every entry.
    always_ff @(negedge reg_clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == CLR_SWEEP) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_qual) begin
            r_mem[RdC] <= w_merged;
        end
    end

    // Status flags are registered from the state, so they trail it by one edge.
    always_ff @(negedge reg_clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            r_state    <= CLR_IDLE;
            r_cnt      <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
            r_wr_drop  <= 1'b0;
        end else begin
            r_clr_busy <= (r_state == CLR_SWEEP);
            r_clr_done <= (r_state == CLR_DONE);
            if (w_wr_req && (r_state != CLR_IDLE)) begin
                r_wr_drop <= 1'b1;
            end
            case (r_state)
                CLR_IDLE: begin
                    if (clr_req) begin
                        r_state <= CLR_SWEEP;
                        r_cnt   <= '0;
                    end
                end
                CLR_SWEEP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= CLR_DONE;
                    end
                end
                CLR_DONE: r_state <= CLR_IDLE;
                default:  r_state <= CLR_IDLE;
            endcase
        end
    end

    assign clr_busy = r_clr_busy;
    assign clr_done = r_clr_done;
    assign wr_drop  = r_wr_drop;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

        regfile_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .i_ena     (reg_ena),
            .i_addr    (w_addr),
            .i_stored  (r_mem[w_addr]),
            .i_wr_qual (w_wr_qual),
            .i_wr_addr (RdC),
            .i_merged  (w_merged),
            .o_data    (rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule
